// File: rtl/vcode_val_seq.sv
// Receive-side RIFL frame validator: serial CRC with the expected frame ID folded in,
// data/control classification, go-back-N sequencing with NACK requests, and link statistics.
module vcode_val_seq #(
  parameter int                   FRAME_WIDTH     = 256,
  parameter int                   DWIDTH          = 64,
  parameter int                   CRC_WIDTH       = 12,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY        = 12'h02f,
  parameter int                   FRAME_ID_WIDTH  = 8,
  parameter int                   ROLLBACK_CYCLES = 16,
  parameter int                   STAT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sof,
  input  logic                      rx_up,
  input  logic [DWIDTH-1:0]         data_in,
  input  logic                      clear_stats,
  output logic                      crc_good_out,
  output logic                      ctrl_good_out,
  output logic                      isdata,
  output logic                      rx_error,
  output logic                      nack_req,
  output logic [FRAME_ID_WIDTH-1:0] nack_id,
  output logic [STAT_WIDTH-1:0]     good_cnt,
  output logic [STAT_WIDTH-1:0]     err_cnt,
  output logic [STAT_WIDTH-1:0]     dup_cnt,
  output logic [STAT_WIDTH-1:0]     abort_cnt
);

  localparam int BEATS = FRAME_WIDTH / DWIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]             LAST_BEAT = BW'(BEATS - 1);
  localparam logic [FRAME_ID_WIDTH-1:0] ROLLBACK  = FRAME_ID_WIDTH'(ROLLBACK_CYCLES);
  localparam logic [DWIDTH-1:0]         TAIL_MASK = {{(DWIDTH-CRC_WIDTH){1'b1}}, {CRC_WIDTH{1'b0}}};
  localparam logic [1:0]                HDR_DATA  = 2'b01;
  localparam logic [1:0]                HDR_CTRL  = 2'b10;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                    state, state_nx;
  logic [BW-1:0]             beat_cnt, beat_cnt_nx;
  logic [CRC_WIDTH-1:0]      crc_acc, crc_cur;
  logic [1:0]                hdr_q, hdr_cur;
  logic [FRAME_ID_WIDTH-1:0] frame_id, threshold, frame_id_inc;
  logic                      start, abort_drop, abort_early, beat_live, is_tail;
  logic                      crc_ok, hdr_data, hdr_ctrl;
  logic                      take_good, take_dup, take_ctrl, take_err;
  logic                      isdata_q;
  logic [3:0]                stat_inc;
  logic [3:0][STAT_WIDTH-1:0] stats;

  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c_in,
                                                     input logic [DWIDTH-1:0]    d);
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c = c_in;
    for (int i = DWIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ d[i];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
    end
  end

  // A sof while busy drops the partial frame and restarts at beat 0 in the same cycle.
  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    start       = sof & rx_up;
    abort_drop  = 1'b0;
    abort_early = 1'b0;
    beat_live   = 1'b0;
    is_tail     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          beat_live = 1'b1;
          if (BEATS == 1) begin
            is_tail = 1'b1;
          end else begin
            state_nx    = S_BUSY;
            beat_cnt_nx = BW'(1);
          end
        end
      end
      S_BUSY: begin
        if (!rx_up) begin
          abort_drop  = 1'b1;
          state_nx    = S_IDLE;
          beat_cnt_nx = '0;
        end else if (sof) begin
          abort_early = 1'b1;
          beat_live   = 1'b1;
          beat_cnt_nx = BW'(1);
        end else begin
          beat_live = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            is_tail     = 1'b1;
            state_nx    = S_IDLE;
            beat_cnt_nx = '0;
          end else begin
            beat_cnt_nx = beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx    = S_IDLE;
        beat_cnt_nx = '0;
      end
    endcase
  end

  // The CRC field is zeroed while it passes through the LFSR, then compared against crc ^ ID.
  always_comb begin
    crc_cur      = crc_step(start ? '0 : crc_acc, is_tail ? (data_in & TAIL_MASK) : data_in);
    hdr_cur      = start ? data_in[DWIDTH-1 -: 2] : hdr_q;
    hdr_data     = (hdr_cur == HDR_DATA);
    hdr_ctrl     = (hdr_cur == HDR_CTRL);
    crc_ok       = (data_in[CRC_WIDTH-1:0] == (crc_cur ^ CRC_WIDTH'(frame_id)));
    frame_id_inc = frame_id + 1'b1;
    take_good    = is_tail & hdr_data & crc_ok & (frame_id == threshold);
    take_dup     = is_tail & hdr_data & crc_ok & (frame_id != threshold);
    take_ctrl    = is_tail & hdr_ctrl & crc_ok;
    take_err     = is_tail & (~crc_ok | ~(hdr_data | hdr_ctrl));
    stat_inc     = {abort_drop | abort_early, take_dup, take_err, take_good};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_acc       <= '0;
      hdr_q         <= '0;
      frame_id      <= '0;
      threshold     <= '0;
      crc_good_out  <= 1'b0;
      ctrl_good_out <= 1'b0;
      nack_req      <= 1'b0;
      nack_id       <= '0;
      rx_error      <= 1'b0;
      isdata_q      <= 1'b0;
    end else begin
      crc_acc       <= (beat_live && !is_tail) ? crc_cur : '0;
      crc_good_out  <= take_good;
      ctrl_good_out <= take_ctrl;
      nack_req      <= take_err;
      if (start) begin
        hdr_q <= data_in[DWIDTH-1 -: 2];
      end
      if (take_err) begin
        frame_id <= threshold - ROLLBACK;
        nack_id  <= threshold;
      end else if (take_good) begin
        frame_id  <= frame_id_inc;
        threshold <= threshold + 1'b1;
      end else if (take_dup) begin
        frame_id <= frame_id_inc;
      end
      // Recovery ends once the replay reaches the frame just before the one that failed.
      if (take_err) begin
        rx_error <= 1'b1;
      end else if (is_tail && frame_id_inc == threshold) begin
        rx_error <= 1'b0;
      end
      if (start && !is_tail) begin
        isdata_q <= (data_in[DWIDTH-1 -: 2] == HDR_DATA);
      end else if (is_tail || abort_drop) begin
        isdata_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      stats <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (stat_inc[i] && stats[i] != '1) begin
          stats[i] <= stats[i] + 1'b1;
        end
      end
    end
  end

  assign isdata    = isdata_q & rx_up;
  assign good_cnt  = stats[0];
  assign err_cnt   = stats[1];
  assign dup_cnt   = stats[2];
  assign abort_cnt = stats[3];

endmodule

// File: tb/tb_vcode_val_seq.sv
// Directed bench for vcode_val_seq: frame-level vector table plus hand-written abort,
// wrap, statistics and reset sequences; a narrow-counter instance exercises saturation.
module tb_vcode_val_seq;

  logic        clk, rst, sof, rx_up, clear_stats;
  logic [63:0] data_in;
  logic        crc_good_out, ctrl_good_out, isdata, rx_error, nack_req;
  logic [7:0]  nack_id;
  logic [31:0] good_cnt, err_cnt, dup_cnt, abort_cnt;
  logic        s_crc_good, s_ctrl_good, s_isdata, s_rx_error, s_nack_req;
  logic [7:0]  s_nack_id;
  logic [1:0]  s_good_cnt, s_err_cnt, s_dup_cnt, s_abort_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] hdr;
    logic [7:0] id;
    bit         corrupt;
    bit         exp_good;
    bit         exp_ctrl;
    bit         exp_nack;
    logic [7:0] exp_nack_id;
    bit         exp_rx_err;
  } vec_t;

  vec_t vecs[$];

  vcode_val_seq dut (
    .clk(clk), .rst(rst), .sof(sof), .rx_up(rx_up), .data_in(data_in),
    .clear_stats(clear_stats), .crc_good_out(crc_good_out), .ctrl_good_out(ctrl_good_out),
    .isdata(isdata), .rx_error(rx_error), .nack_req(nack_req), .nack_id(nack_id),
    .good_cnt(good_cnt), .err_cnt(err_cnt), .dup_cnt(dup_cnt), .abort_cnt(abort_cnt)
  );

  vcode_val_seq #(.STAT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .sof(sof), .rx_up(rx_up), .data_in(data_in),
    .clear_stats(clear_stats), .crc_good_out(s_crc_good), .ctrl_good_out(s_ctrl_good),
    .isdata(s_isdata), .rx_error(s_rx_error), .nack_req(s_nack_req), .nack_id(s_nack_id),
    .good_cnt(s_good_cnt), .err_cnt(s_err_cnt), .dup_cnt(s_dup_cnt), .abort_cnt(s_abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC over the whole 256-bit frame, one bit at a time from the MSB.
  function automatic logic [11:0] model_crc(input logic [255:0] f);
    logic [11:0] c;
    c = '0;
    for (int i = 255; i >= 0; i--) begin
      if (c[11] ^ f[i]) c = (c << 1) ^ 12'h02f;
      else              c = c << 1;
    end
    return c;
  endfunction

  function automatic logic [255:0] build_frame(input logic [1:0] hdr, input logic [7:0] id,
                                               input bit corrupt);
    logic [255:0] f;
    for (int w = 0; w < 8; w++) f[w*32 +: 32] = $urandom;
    f[255:254] = hdr;
    f[11:0]    = '0;
    f[11:0]    = model_crc(f) ^ {4'h0, id};
    if (corrupt) f[100] = ~f[100];
    return f;
  endfunction

  function automatic vec_t mkv(input logic [1:0] hdr, input logic [7:0] id, input bit corrupt,
                               input bit good, input bit ctrl, input bit nack,
                               input logic [7:0] nid, input bit rxe);
    vec_t v;
    v.hdr = hdr; v.id = id; v.corrupt = corrupt; v.exp_good = good; v.exp_ctrl = ctrl;
    v.exp_nack = nack; v.exp_nack_id = nid; v.exp_rx_err = rxe;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive_beat(input logic s, input logic up, input logic [63:0] d);
    sof = s; rx_up = up; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [255:0] f;
    f = build_frame(v.hdr, v.id, v.corrupt);
    drive_beat(1'b1, 1'b1, f[255:192]);
    checkOutput($sformatf("good_pulse_end id%0d", v.id), crc_good_out, 0);
    checkOutput($sformatf("ctrl_pulse_end id%0d", v.id), ctrl_good_out, 0);
    checkOutput($sformatf("nack_pulse_end id%0d", v.id), nack_req, 0);
    checkOutput($sformatf("isdata_beat1 id%0d", v.id), isdata, (v.hdr == 2'b01));
    drive_beat(1'b0, 1'b1, f[191:128]);
    drive_beat(1'b0, 1'b1, f[127:64]);
    drive_beat(1'b0, 1'b1, f[63:0]);
    sof = 1'b0; data_in = '0;
    checkOutput($sformatf("crc_good id%0d", v.id), crc_good_out, v.exp_good);
    checkOutput($sformatf("ctrl_good id%0d", v.id), ctrl_good_out, v.exp_ctrl);
    checkOutput($sformatf("nack_req id%0d", v.id), nack_req, v.exp_nack);
    if (v.exp_nack) checkOutput($sformatf("nack_id id%0d", v.id), nack_id, v.exp_nack_id);
    checkOutput($sformatf("rx_error id%0d", v.id), rx_error, v.exp_rx_err);
    checkOutput($sformatf("isdata_after_tail id%0d", v.id), isdata, 0);
  endtask

  task automatic check_counters(input string tag, input int g, input int e, input int d, input int a);
    checkOutput({tag, " good_cnt"}, good_cnt, g);
    checkOutput({tag, " err_cnt"}, err_cnt, e);
    checkOutput({tag, " dup_cnt"}, dup_cnt, d);
    checkOutput({tag, " abort_cnt"}, abort_cnt, a);
  endtask

  initial begin
    logic [255:0] f;
    rst = 1'b1; sof = 1'b0; rx_up = 1'b0; data_in = '0; clear_stats = 1'b0;

    // Frame table: in-order run, corruption of ID 20 with replay, control frames,
    // an invalid header with replay, then resumed delivery.
    for (int i = 0; i < 20; i++) vecs.push_back(mkv(2'b01, 8'(i), 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'd20, 1, 0, 0, 1, 8'd20, 1));
    for (int i = 4; i < 19; i++) vecs.push_back(mkv(2'b01, 8'(i), 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(2'b01, 8'd19, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'd20, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 8'd21, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 8'd21, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'd21, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b11, 8'd22, 0, 0, 0, 1, 8'd22, 1));
    for (int i = 6; i < 21; i++) vecs.push_back(mkv(2'b01, 8'(i), 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(2'b01, 8'd21, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'd22, 0, 1, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset crc_good", crc_good_out, 0);
    checkOutput("reset ctrl_good", ctrl_good_out, 0);
    checkOutput("reset nack_req", nack_req, 0);
    checkOutput("reset nack_id", nack_id, 0);
    checkOutput("reset rx_error", rx_error, 0);
    checkOutput("reset isdata", isdata, 0);
    check_counters("reset", 0, 0, 0, 0);
    rst = 1'b0; rx_up = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (i == 2) check_counters("first3", 3, 0, 0, 0);
    end
    check_counters("table", 23, 2, 32, 0);
    checkOutput("sat good_cnt table", s_good_cnt, 3);
    checkOutput("sat err_cnt table", s_err_cnt, 2);

    // rx_up loss on beat 2 discards the frame without touching the ID state.
    f = build_frame(2'b01, 8'd23, 0);
    drive_beat(1'b1, 1'b1, f[255:192]);
    drive_beat(1'b0, 1'b1, f[191:128]);
    sof = 1'b0; rx_up = 1'b0; data_in = f[127:64];
    #1;
    checkOutput("isdata rx_down", isdata, 0);
    @(posedge clk);
    #1;
    checkOutput("drop crc_good", crc_good_out, 0);
    checkOutput("drop nack_req", nack_req, 0);
    checkOutput("drop abort_cnt", abort_cnt, 1);
    rx_up = 1'b1;
    applyStimulus(mkv(2'b01, 8'd23, 0, 1, 0, 0, 0, 0));

    // Early sof on beat 1 restarts with the new frame.
    f = build_frame(2'b01, 8'd24, 0);
    drive_beat(1'b1, 1'b1, f[255:192]);
    applyStimulus(mkv(2'b01, 8'd24, 0, 1, 0, 0, 0, 0));
    check_counters("aborts", 25, 2, 32, 2);

    // ID wrap, then an error at threshold 3 rolls back to 243.
    for (int i = 25; i < 256; i++) applyStimulus(mkv(2'b01, 8'(i), 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) applyStimulus(mkv(2'b01, 8'(i), 0, 1, 0, 0, 0, 0));
    applyStimulus(mkv(2'b01, 8'd3, 1, 0, 0, 1, 8'd3, 1));
    for (int i = 243; i < 258; i++) applyStimulus(mkv(2'b01, 8'(i), 0, 0, 0, 0, 0, 1));
    applyStimulus(mkv(2'b01, 8'd2, 0, 0, 0, 0, 0, 0));
    applyStimulus(mkv(2'b01, 8'd3, 0, 1, 0, 0, 0, 0));
    check_counters("wrap", 260, 3, 48, 2);
    checkOutput("sat good_cnt hold", s_good_cnt, 3);
    checkOutput("sat dup_cnt hold", s_dup_cnt, 3);
    checkOutput("sat abort_cnt", s_abort_cnt, 2);

    // clear_stats on the tail of an accepted frame wins over the increment.
    f = build_frame(2'b01, 8'd4, 0);
    drive_beat(1'b1, 1'b1, f[255:192]);
    drive_beat(1'b0, 1'b1, f[191:128]);
    drive_beat(1'b0, 1'b1, f[127:64]);
    clear_stats = 1'b1;
    drive_beat(1'b0, 1'b1, f[63:0]);
    clear_stats = 1'b0; sof = 1'b0; data_in = '0;
    checkOutput("clear crc_good", crc_good_out, 1);
    checkOutput("clear rx_error", rx_error, 0);
    check_counters("clear", 0, 0, 0, 0);
    checkOutput("clear sat good_cnt", s_good_cnt, 0);
    applyStimulus(mkv(2'b01, 8'd5, 0, 1, 0, 0, 0, 0));
    check_counters("post_clear", 1, 0, 0, 0);

    // Reset mid-frame: the partial frame leaves no trace and IDs restart at 0.
    f = build_frame(2'b01, 8'd6, 0);
    drive_beat(1'b1, 1'b1, f[255:192]);
    drive_beat(1'b0, 1'b1, f[191:128]);
    rst = 1'b1;
    drive_beat(1'b0, 1'b1, f[127:64]);
    rst = 1'b0; sof = 1'b0; data_in = '0;
    checkOutput("midreset isdata", isdata, 0);
    check_counters("midreset", 0, 0, 0, 0);
    applyStimulus(mkv(2'b01, 8'd0, 0, 1, 0, 0, 0, 0));
    check_counters("after_reset", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vcode_val_seq.md
Name: vcode_val_seq

Overview:
- Receive-side frame validator and sequencer for multi-beat RIFL frames, one beat per cycle after the descrambler.
- Computes a serial MSB-first CRC over each frame, with the expected frame ID folded into the CRC field, and classifies each frame as data, control or invalid.
- Enforces in-order delivery with a go-back-N rollback window and issues NACK requests on failure.
- Keeps saturating statistics counters for link monitoring.

Parameters:
- FRAME_WIDTH, 256, frame size in bits; must equal DWIDTH times a power of two.
- DWIDTH, 64, beat width in bits; BEATS = FRAME_WIDTH/DWIDTH, and BEATS=1 is legal.
- CRC_WIDTH, 12, CRC field width, taken from the LSBs of the tail beat.
- CRC_POLY, 12'h02f, generator polynomial in normal representation (implicit x^CRC_WIDTH term).
- FRAME_ID_WIDTH, 8, sequence ID width; must be <= CRC_WIDTH.
- ROLLBACK_CYCLES, 16, replay window depth in frames; must be < 2^FRAME_ID_WIDTH.
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sof  in  1  current beat is the first beat of a frame
- rx_up  in  1  link up; qualifies sof and every beat
- data_in  in  DWIDTH  descrambled beat; the header is in bits [DWIDTH-1 -: 2] of the first beat
- clear_stats  in  1  synchronously clears all statistics counters
- crc_good_out  out  1  1-cycle pulse: new in-order data frame accepted
- ctrl_good_out  out  1  1-cycle pulse: control frame passed CRC
- isdata  out  1  high for the beats of a frame whose header is 2'b01
- rx_error  out  1  sticky error flag, high while recovering
- nack_req  out  1  1-cycle pulse requesting retransmission
- nack_id  out  FRAME_ID_WIDTH  ID to resend from; valid while nack_req is high
- good_cnt  out  STAT_WIDTH  accepted data frames
- err_cnt  out  STAT_WIDTH  CRC or header failures
- dup_cnt  out  STAT_WIDTH  correct-CRC data frames dropped as replays
- abort_cnt  out  STAT_WIDTH  frames truncated by rx_up loss or an early sof

Behaviour:
- All outputs reset to 0. Internal state resets to frame_id=0, threshold=0, beat counter idle, CRC accumulator 0.
- Beat counter states:
  - IDLE: sof&rx_up starts a frame at beat 0.
  - Beats 1..BEATS-1 follow on consecutive cycles; the tail beat is BEATS-1. With BEATS=1 the sof beat is also the tail.
- Aborts:
  - rx_up=0 on any non-idle beat: the frame is discarded, the counter returns to IDLE, abort_cnt increments, and no other state changes.
  - sof&rx_up before the tail: the current frame is discarded, abort_cnt increments, and the new frame starts at beat 0 in the same cycle.
- CRC computation:
  - Serial LFSR, initial value 0, input bits taken MSB-first across beats.
  - Per bit: fb = crc[MSB] ^ bit; crc = {crc[CRC_WIDTH-2:0],0} ^ (fb ? CRC_POLY : 0).
  - On the tail beat, the low CRC_WIDTH bits are replaced with zeros before entering the LFSR.
  - The accumulator is registered between beats and cleared after the tail or an abort.
- Check, evaluated combinationally on the tail beat:
  - crc_ok = (tail[CRC_WIDTH-1:0] == computed ^ zero-extended frame_id).
  - The header is latched on beat 0: 2'b01 = data, 2'b10 = control, anything else = invalid.
- Tail-beat updates (all ID arithmetic modulo 2^FRAME_ID_WIDTH):
  - Data with crc_ok and frame_id==threshold: frame_id+1, threshold+1, crc_good_out and good_cnt++.
  - Data with crc_ok and frame_id!=threshold: frame_id+1, dup_cnt++, no delivery.
  - Control with crc_ok: no ID change, ctrl_good_out pulses.
  - Not crc_ok, or invalid header: frame_id <= threshold-ROLLBACK_CYCLES, rx_error<=1, nack_req pulses with nack_id=threshold, err_cnt++.
  - rx_error clears on a tail with crc_ok and frame_id+1==threshold. If it is already clear, it stays clear.
- Output timing:
  - crc_good_out, ctrl_good_out and nack_req are registered, asserted in the cycle after the tail beat, for 1 cycle.
  - isdata is registered: it rises the cycle after the sof beat of a data frame, falls the cycle after the tail or abort, and is 0 whenever rx_up=0.
- Statistics counters:
  - Saturate at all-ones.
  - clear_stats takes priority over a same-cycle increment.
  - clear_stats does not affect the ID state or rx_error.
- Reset mid-frame: every output and state item returns to its reset value on the next edge, and the partial frame is not counted.

Test Plan (defaults, BEATS=4):
- Reset, then 3 good data frames with IDs 0,1,2 back-to-back -> crc_good_out pulses 1 cycle after each tail, good_cnt=3, rx_error=0, nack_req never asserted.
- After 20 good frames, corrupt one bit of frame ID 20 -> nack_req with nack_id=20, rx_error=1, err_cnt=1, internal frame_id=4.
  - Replay IDs 4..19 -> dup_cnt=16, no crc_good_out, rx_error clears after the tail of ID 19.
  - Replay of ID 20 -> crc_good_out, good_cnt=21.
- Control frame (header 2'b10, valid CRC using frame_id=5) -> ctrl_good_out 1 pulse, isdata stays 0, frame_id stays 5. Header 2'b11 -> err_cnt++ and nack_req.
- Drop rx_up during beat 2 -> abort_cnt=1, no pulses, ID unchanged; the next sof frame validates normally. An early sof at beat 1 also gives abort_cnt++ and the new frame is accepted.
- Wrap: deliver IDs 0..255, then 0 -> threshold wraps to 1. Error at threshold=3 -> frame_id=243 (3-16 mod 256), nack_id=3.
- Force good_cnt to all-ones and deliver a frame -> the counter holds. clear_stats in the same cycle as an increment -> the counter reads 0.
